// File: rtl/blackjack_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_interval_timer
// Brief    : Prescaled tick timer with one-shot/periodic modes, pause, restart
//            and clear; optional shuffler seed counter (BLACKJACK_TIMER_SEED_EN).
// Revision : 1.0 - initial release
// ============================================================================
module blackjack_interval_timer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 2000,
    parameter int WIDTH      = 12,
    parameter int SEED_WIDTH = 16
) (
    input  logic                  clk_50M,
    input  logic                  i_Rst_n,
    input  logic                  i_Start,
    input  logic                  i_Clear,
    input  logic                  i_Pause,
    input  logic                  i_Mode,
    input  logic [WIDTH-1:0]      i_Limit,
    input  logic                  i_Seed_En,
    output logic [WIDTH-1:0]      o_Count,
    output logic                  o_Busy,
    output logic                  o_Tick,
    output logic                  o_Expired,
    output logic                  o_Done,
    output logic [SEED_WIDTH-1:0] o_Seed
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    generate
        if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_div_check
            $error("CLK_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [WIDTH-1:0]  count_nxt, count_inc;
    logic [WIDTH-1:0]  limit_q, limit_nxt;
    logic              mode_q, mode_nxt;
    logic              done_nxt, busy_nxt, tick_nxt, expired_nxt;

    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            o_Count   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            o_Done    <= 1'b0;
            o_Busy    <= 1'b0;
            o_Tick    <= 1'b0;
            o_Expired <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            o_Count   <= count_nxt;
            limit_q   <= limit_nxt;
            mode_q    <= mode_nxt;
            o_Done    <= done_nxt;
            o_Busy    <= busy_nxt;
            o_Tick    <= tick_nxt;
            o_Expired <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        count_nxt   = o_Count;
        limit_nxt   = limit_q;
        mode_nxt    = mode_q;
        done_nxt    = o_Done;
        tick_nxt    = 1'b0;
        expired_nxt = 1'b0;
        count_inc   = o_Count + WIDTH'(1);

        if (i_Clear) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            count_nxt = '0;
            done_nxt  = 1'b0;
        end else if (i_Start) begin
            state_nxt = RUN;
            limit_nxt = i_Limit;
            mode_nxt  = i_Mode;
            presc_nxt = '0;
            count_nxt = '0;
            done_nxt  = 1'b0;
        end else if ((state == RUN) || (state == PAUSED)) begin
            if (i_Pause) begin
                state_nxt = PAUSED;
            end else begin
                // Leaving PAUSED advances the prescaler on the same edge so a
                // pause of P cycles costs exactly P cycles.
                state_nxt = RUN;
                if (presc == PRESC_MAX) begin
                    presc_nxt = '0;
                    tick_nxt  = 1'b1;
                    count_nxt = count_inc;
                    if (count_inc == limit_q) begin
                        expired_nxt = 1'b1;
                        done_nxt    = 1'b1;
                        if (mode_q) begin
                            count_nxt = '0;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
        end

        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSED);
    end

`ifdef BLACKJACK_TIMER_SEED_EN
    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Seed <= '0;
        end else if (i_Seed_En) begin
            o_Seed <= o_Seed + SEED_WIDTH'(1);
        end
    end
`else
    logic unused_seed_en;
    assign unused_seed_en = i_Seed_En;
    assign o_Seed         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blackjack_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blackjack_interval_timer
// Brief    : Scoreboard bench for blackjack_interval_timer (DIV=5, WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_blackjack_interval_timer;

    localparam int CLK_HZ     = 10;
    localparam int TICK_HZ    = 2;
    localparam int WIDTH      = 4;
    localparam int SEED_WIDTH = 16;
`ifdef BLACKJACK_TIMER_SEED_EN
    localparam int SEED_EXP = 20;
`else
    localparam int SEED_EXP = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start, clear, pause, mode, seed_en;
    logic [WIDTH-1:0]      limit;
    logic [WIDTH-1:0]      count;
    logic                  busy, tick, expired, done;
    logic [SEED_WIDTH-1:0] seed;

    blackjack_interval_timer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH), .SEED_WIDTH(SEED_WIDTH)
    ) dut (
        .clk_50M(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Clear(clear),
        .i_Pause(pause), .i_Mode(mode), .i_Limit(limit), .i_Seed_En(seed_en),
        .o_Count(count), .o_Busy(busy), .o_Tick(tick), .o_Expired(expired),
        .o_Done(done), .o_Seed(seed)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             at;
        logic           exp;
        logic [WIDTH-1:0] cnt;
        logic           dn;
    } ev_t;
    ev_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int at, input logic exp, input int cnt, input logic dn);
        ev_t e;
        e.at = at; e.exp = exp; e.cnt = WIDTH'(cnt); e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_start(input int lim, input logic md, output int s);
        start = 1'b1;
        limit = WIDTH'(lim);
        mode  = md;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every tick/expiry presented by the DUT is matched against the queue.
    always @(negedge clk) begin
        if (tick || expired) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_cycle",   cyc, e.at);
                chk("ev_tick",    int'(tick), 1);
                chk("ev_expired", int'(expired), int'(e.exp));
                chk("ev_count",   int'(count), int'(e.cnt));
                chk("ev_done",    int'(done), int'(e.dn));
            end
        end
    end

    initial begin
        int s, s2;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; pause = 1'b0;
        mode = 1'b0; seed_en = 1'b0; limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_count",   int'(count), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_tick",    int'(tick), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_done",    int'(done), 0);
        chk("rst_seed",    int'(seed), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot, limit 3
        do_start(3, 1'b0, s);
        push(s + 5, 1'b0, 1, 1'b0);
        push(s + 10, 1'b0, 2, 1'b0);
        push(s + 15, 1'b1, 3, 1'b1);
        chk("os_busy_start",  int'(busy), 1);
        chk("os_count_start", int'(count), 0);
        wait_until(s + 16);
        chk("os_busy_end",  int'(busy), 0);
        chk("os_done_end",  int'(done), 1);
        chk("os_count_end", int'(count), 3);

        // Periodic, limit 2
        do_start(2, 1'b1, s);
        chk("per_done_cleared", int'(done), 0);
        for (int k = 1; k <= 6; k++) push(s + 5 * k, (k % 2) == 0, k % 2, k >= 2);
        wait_until(s + 32);
        chk("per_busy", int'(busy), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy",  int'(busy), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_done",  int'(done), 0);

        // Limit 0 means 16 ticks
        do_start(0, 1'b0, s);
        for (int k = 1; k <= 16; k++) push(s + 5 * k, k == 16, k % 16, k == 16);
        wait_until(s + 82);
        chk("lim0_count", int'(count), 0);
        chk("lim0_done",  int'(done), 1);
        chk("lim0_busy",  int'(busy), 0);

        // Pause sampled on edges s+3..s+9
        do_start(2, 1'b0, s);
        push(s + 12, 1'b0, 1, 1'b0);
        push(s + 17, 1'b1, 2, 1'b1);
        wait_until(s + 2);
        pause = 1'b1;
        wait_until(s + 6);
        chk("pause_busy",  int'(busy), 1);
        chk("pause_count", int'(count), 0);
        wait_until(s + 9);
        pause = 1'b0;
        wait_until(s + 18);
        chk("pause_done", int'(done), 1);
        chk("pause_busy_end", int'(busy), 0);

        // Restart on the would-be expiry edge
        do_start(1, 1'b0, s);
        wait_until(s + 4);
        do_start(1, 1'b0, s2);
        chk("col_count",   int'(count), 0);
        chk("col_done",    int'(done), 0);
        chk("col_expired", int'(expired), 0);
        chk("col_busy",    int'(busy), 1);
        push(s2 + 5, 1'b1, 1, 1'b1);
        wait_until(s2 + 6);
        chk("col_done_end", int'(done), 1);

        // Clear together with start ends idle
        do_start(5, 1'b0, s);
        wait_until(s + 2);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        chk("cs_busy",  int'(busy), 0);
        chk("cs_count", int'(count), 0);
        wait_until(s + 15);
        chk("cs_busy_late", int'(busy), 0);

        // Asynchronous reset mid-count
        do_start(3, 1'b0, s);
        push(s + 5, 1'b0, 1, 1'b0);
        wait_until(s + 7);
        chk("ar_count_pre", int'(count), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_busy",  int'(busy), 0);
        chk("ar_tick",  int'(tick), 0);
        chk("ar_done",  int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("ar_idle_busy",  int'(busy), 0);
        chk("ar_idle_count", int'(count), 0);

        // Seed counter
        seed_en = 1'b1;
        repeat (20) @(negedge clk);
        seed_en = 1'b0;
        chk("seed_value", int'(seed), SEED_EXP);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("seed_after_clear", int'(seed), SEED_EXP);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
